// File: rtl/uart_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_pkg : shared UART framing constants and arbiter state codes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_tx_arbiter_pkg;

    localparam int DATA_W           = 8;
    localparam int FRAME_CYCLES_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ----------------------------------------------------------------------------
// uart_rr_pick : combinational round-robin picker, searches from last+1 upward
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Walk the ring from farthest to nearest so the nearest set bit wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % N_REQ]) begin
                valid = 1'b1;
                index = IDX_W'((int'(last) + k) % N_REQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter : round-robin sharing of one uart_tx_moore between requesters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                     clk_baud,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [DATA_W*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [DATA_W-1:0]        bus_out,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     zero_drop
);

    localparam int c_idx_w = $clog2(N_REQ);
    localparam int c_cnt_w = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);

    arb_state_t          r_state,  w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt,    w_cnt_nxt;
    logic [c_idx_w-1:0]  r_last,   w_last_nxt;
    logic [N_REQ-1:0]    r_gnt,    w_gnt_nxt;
    logic [DATA_W-1:0]   r_bus,    w_bus_nxt;
    logic                r_busy,   w_busy_nxt;
    logic [c_idx_w-1:0]  r_gid,    w_gid_nxt;
    logic                r_zd,     w_zd_nxt;

    logic                w_arb;
    logic [N_REQ-1:0]    w_req_eff;
    logic                w_pick_valid;
    logic [c_idx_w-1:0]  w_pick_idx;
    logic [DATA_W-1:0]   w_pick_data;

    // A requester is invisible during the cycle its own gnt is showing.
    assign w_req_eff   = req & ~r_gnt;
    assign w_pick_data = DATA_W'(req_data >> (DATA_W * int'(w_pick_idx)));

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (c_idx_w)
    ) u_pick (
        .req   (w_req_eff),
        .last  (r_last),
        .valid (w_pick_valid),
        .index (w_pick_idx)
    );

    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= c_idx_w'(N_REQ - 1);
            r_gnt   <= '0;
            r_bus   <= '0;
            r_busy  <= 1'b0;
            r_gid   <= '0;
            r_zd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_bus   <= w_bus_nxt;
            r_busy  <= w_busy_nxt;
            r_gid   <= w_gid_nxt;
            r_zd    <= w_zd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_gnt_nxt   = '0;
        w_bus_nxt   = '0;
        w_busy_nxt  = r_busy;
        w_gid_nxt   = r_gid;
        w_zd_nxt    = 1'b0;
        w_arb       = 1'b0;

        case (r_state)
            ST_IDLE: w_arb = 1'b1;
            ST_SEND: begin
                if (r_cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = c_cnt_w'(GAP_CYCLES - 1);
                    end else begin
                        w_arb = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) w_arb = 1'b1;
                else             w_cnt_nxt = r_cnt - 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_arb) begin
            if (!w_pick_valid) begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end else begin
                w_gnt_nxt  = N_REQ'(1) << w_pick_idx;
                w_last_nxt = w_pick_idx;
                w_gid_nxt  = w_pick_idx;
                // A zero byte cannot be launched; hold at the arbitration point.
                if (w_pick_data == '0) begin
                    w_zd_nxt = 1'b1;
                end else begin
                    w_bus_nxt   = w_pick_data;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SEND;
                    w_cnt_nxt   = c_cnt_w'(FRAME_CYCLES - 1);
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign bus_out   = r_bus;
    assign busy      = r_busy;
    assign grant_id  = r_gid;
    assign zero_drop = r_zd;

endmodule

`default_nettype wire
